alu_host_seq: RTL and testbench



---
 rtl/alu_host_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_host_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_host_seq.sv
// Command-level initiator for the serial alu core: drives the BEGIN/op_code/inbus start
// sequence, captures the result bytes on END and returns them on a valid/ready response port.
// Optional WAIT watchdog compiled in with `define ALU_HOST_TIMEOUT_EN.
module alu_host_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_timeout,
    output logic        alu_begin,
    output logic [1:0]  alu_op_code,
    output logic [7:0]  alu_inbus,
    input  logic [7:0]  alu_outbus,
    input  logic        alu_end
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] OPA    = 3'd2;
    localparam logic [2:0] OPB    = 3'd3;
    localparam logic [2:0] WAIT   = 3'd4;
    localparam logic [2:0] CAP_LO = 3'd5;
    localparam logic [2:0] RESP   = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] rsp_data_q, rsp_data_d;

`ifdef ALU_HOST_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wdog_q, wdog_d;
    logic        rsp_timeout_q, rsp_timeout_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_data_d = rsp_data_q;
`ifdef ALU_HOST_TIMEOUT_EN
        wdog_d        = wdog_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d       = cmd_op;
                    a_d        = cmd_a;
                    b_d        = cmd_b;
                    rsp_data_d = 16'h0000;
                    state_d    = START;
                end
            end
            START: state_d = OPA;
            OPA:   state_d = OPB;
            OPB: begin
                state_d = WAIT;
`ifdef ALU_HOST_TIMEOUT_EN
                wdog_d = 16'h0000;
`endif
            end
            WAIT: begin
                if (alu_end) begin
                    // MUL/DIV deliver the high byte first, low byte on the following cycle.
                    if (op_q[1]) begin
                        rsp_data_d[15:8] = alu_outbus;
                        state_d          = CAP_LO;
                    end else begin
                        rsp_data_d = {8'h00, alu_outbus};
                        state_d    = RESP;
                    end
                end
`ifdef ALU_HOST_TIMEOUT_EN
                else if (wdog_q == WDOG_LAST) begin
                    rsp_data_d    = 16'h0000;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
`endif
            end
            CAP_LO: begin
                rsp_data_d[7:0] = alu_outbus;
                state_d         = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
`ifdef ALU_HOST_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            op_q       <= 2'b00;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            rsp_data_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rsp_data_q <= rsp_data_d;
        end
    end

`ifdef ALU_HOST_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_q        <= 16'h0000;
            rsp_timeout_q <= 1'b0;
        end else begin
            wdog_q        <= wdog_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    // Gating with reset keeps cmd_ready low while reset is held, even though state is IDLE.
    assign cmd_ready   = reset && (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_data    = rsp_data_q;
    assign alu_begin   = (state_q == START) || (state_q == OPA);
    assign alu_op_code = (state_q == IDLE) ? 2'b00 : op_q;

    always_comb begin
        alu_inbus = 8'h00;
        case (state_q)
            OPA:       alu_inbus = a_q;
            OPB, WAIT: alu_inbus = b_q;
            default:   alu_inbus = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_alu_host_seq.sv
// Directed self-checking bench for alu_host_seq; the bench itself plays the ALU's END/outbus side.
// Define ALU_HOST_TIMEOUT_EN for both files to exercise the watchdog case.
module tb_alu_host_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [7:0]  cmd_a = 8'h00;
    logic [7:0]  cmd_b = 8'h00;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_timeout;
    logic        alu_begin;
    logic [1:0]  alu_op_code;
    logic [7:0]  alu_inbus;
    logic [7:0]  alu_outbus = 8'h00;
    logic        alu_end = 1'b0;

    int checks = 0;
    int errors = 0;

    alu_host_seq #(.TIMEOUT_CYCLES(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .alu_begin   (alu_begin),
        .alu_op_code (alu_op_code),
        .alu_inbus   (alu_inbus),
        .alu_outbus  (alu_outbus),
        .alu_end     (alu_end)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, act as the ALU (END after wait_cycles WAIT cycles), check the response.
    task automatic run_op(input string name, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input int wait_cycles, input logic [7:0] hi,
                          input logic [7:0] lo, input logic [15:0] exp, input int hold,
                          input logic early_ready);
        check_eq({name, " cmd_ready idle"}, 16'(cmd_ready), 16'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        rsp_ready = early_ready;
        step();
        cmd_valid = 1'b0;
        check_eq({name, " start begin"}, 16'(alu_begin), 16'd1);
        check_eq({name, " start inbus"}, 16'(alu_inbus), 16'h00);
        check_eq({name, " start op"}, 16'(alu_op_code), 16'(op));
        check_eq({name, " start cmd_ready"}, 16'(cmd_ready), 16'd0);
        step();
        check_eq({name, " opa begin"}, 16'(alu_begin), 16'd1);
        check_eq({name, " opa inbus"}, 16'(alu_inbus), 16'(a));
        step();
        check_eq({name, " opb begin"}, 16'(alu_begin), 16'd0);
        check_eq({name, " opb inbus"}, 16'(alu_inbus), 16'(b));
        step();
        for (int i = 0; i < wait_cycles; i++) begin
            check_eq({name, " wait no rsp"}, 16'(rsp_valid), 16'd0);
            step();
        end
        check_eq({name, " wait inbus"}, 16'(alu_inbus), 16'(b));
        check_eq({name, " wait op"}, 16'(alu_op_code), 16'(op));
        alu_end    = 1'b1;
        alu_outbus = op[1] ? hi : lo;
        step();
        alu_end = 1'b0;
        if (op[1]) begin
            check_eq({name, " cap_lo no rsp"}, 16'(rsp_valid), 16'd0);
            alu_outbus = lo;
            step();
        end
        alu_outbus = 8'hEE;
        check_eq({name, " rsp_valid"}, 16'(rsp_valid), 16'd1);
        check_eq({name, " rsp_data"}, rsp_data, exp);
        check_eq({name, " rsp_timeout"}, 16'(rsp_timeout), 16'd0);
        for (int i = 0; i < hold; i++) begin
            step();
            check_eq({name, " hold valid"}, 16'(rsp_valid), 16'd1);
            check_eq({name, " hold data"}, rsp_data, exp);
            check_eq({name, " hold cmd_ready"}, 16'(cmd_ready), 16'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_eq({name, " rsp done"}, 16'(rsp_valid), 16'd0);
        check_eq({name, " back to idle"}, 16'(cmd_ready), 16'd1);
    endtask

    initial begin
        step();
        check_eq("reset cmd_ready", 16'(cmd_ready), 16'd0);
        check_eq("reset rsp_valid", 16'(rsp_valid), 16'd0);
        check_eq("reset rsp_data", rsp_data, 16'h0000);
        check_eq("reset alu_begin", 16'(alu_begin), 16'd0);
        check_eq("reset alu_inbus", 16'(alu_inbus), 16'h00);
        @(negedge clk);
        reset = 1'b1;
        step();
        check_eq("post-reset cmd_ready", 16'(cmd_ready), 16'd1);

        run_op("ADD", 2'b00, 8'd56, 8'd89, 2, 8'h00, 8'h91, 16'h0091, 0, 1'b0);
        run_op("SUB", 2'b01, 8'd56, 8'd89, 0, 8'h00, 8'hDF, 16'h00DF, 0, 1'b1);
        run_op("MUL", 2'b10, 8'd7, 8'd3, 3, 8'h00, 8'h15, 16'h0015, 0, 1'b0);
        run_op("DIV", 2'b11, 8'd89, 8'd7, 1, 8'h05, 8'h0C, 16'h050C, 10, 1'b0);

`ifdef ALU_HOST_TIMEOUT_EN
        begin
            int n;
            cmd_valid = 1'b1;
            cmd_op    = 2'b00;
            cmd_a     = 8'd9;
            cmd_b     = 8'd9;
            step();
            cmd_valid = 1'b0;
            step();
            step();
            step();
            n = 0;
            while (!rsp_valid && n < 200) begin
                step();
                n++;
            end
            check_eq("timeout latency", 16'(n), 16'd64);
            check_eq("timeout flag", 16'(rsp_timeout), 16'd1);
            check_eq("timeout data", rsp_data, 16'h0000);
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            check_eq("timeout flag cleared", 16'(rsp_timeout), 16'd0);
            run_op("ADD1+1", 2'b00, 8'd1, 8'd1, 0, 8'h00, 8'h02, 16'h0002, 0, 1'b0);
        end
`endif

        // Reset asserted in WAIT must clear outputs without waiting for a clock edge.
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_a     = 8'd4;
        cmd_b     = 8'd5;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        step();
        check_eq("midop in wait inbus", 16'(alu_inbus), 16'd5);
        #2;
        reset = 1'b0;
        #1;
        check_eq("midop async inbus", 16'(alu_inbus), 16'h00);
        check_eq("midop async op", 16'(alu_op_code), 16'd0);
        check_eq("midop async cmd_ready", 16'(cmd_ready), 16'd0);
        check_eq("midop async rsp_valid", 16'(rsp_valid), 16'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        check_eq("midop release cmd_ready", 16'(cmd_ready), 16'd1);
        alu_end    = 1'b1;
        alu_outbus = 8'h55;
        step();
        alu_end = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("stray end no rsp", 16'(rsp_valid), 16'd0);
            step();
        end
        check_eq("stray end data", rsp_data, 16'h0000);
        check_eq("stray end idle", 16'(cmd_ready), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
